barrel_shift_arbiter: RTL
=========================

BARREL_SHIFT_ARBITER -- requirements
Module: barrel_shift_arbiter

Interface
REQ-001 Parameter W, default 8, data width of shifter operands.
REQ-002 Parameter LOG2W, default 3, width of shift-amount field.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  2  per-requester request valid, bit i = requester i.
REQ-006 req_ready  output  2  per-requester request accepted this cycle, bit i = requester i.
REQ-007 req_dir  input  2  per-requester shift direction: 0 = left, 1 = right.
REQ-008 req_op  input  2  per-requester operation: 0 = shift, 1 = rotate.
REQ-009 req_shift_t  input  2  per-requester fill type: 0 = logical, 1 = arithmetic (right shift only).
REQ-010 req_sel  input  2*LOG2W  per-requester shift amount, slice i = requester i.
REQ-011 req_in  input  2*W  per-requester operand, slice i = requester i.
REQ-012 rsp_valid  output  1  response valid.
REQ-013 rsp_id  output  1  requester index owning the response.
REQ-014 rsp_data  output  W  shifted result.
REQ-015 rsp_ready  input  1  consumer accepts response.

Function
REQ-016 Block SHALL share one barrel_shifter instance between two requesters, one transaction in flight.
REQ-017 FSM states SHALL be IDLE, EXEC, RESP.
REQ-018 IDLE: if any req_valid, SHALL grant one requester, assert its req_ready bit for that cycle only, capture its dir/op/shift_t/sel/in and index into operand registers, go to EXEC.
REQ-019 req_ready SHALL be 0 in EXEC and RESP; at most one req_ready bit high per cycle.
REQ-020 Arbitration SHALL be round-robin: on simultaneous requests, the requester not granted last wins; single request always wins; last-grant pointer resets to 1 (requester 0 wins the first tie).
REQ-021 EXEC: registered operands SHALL drive the shifter; result SHALL be latched into rsp_data, index into rsp_id; go to RESP.
REQ-022 RESP: rsp_valid SHALL be 1; rsp_data and rsp_id SHALL stay stable until rsp_valid && rsp_ready.
REQ-023 On rsp_ready in RESP, SHALL return to IDLE; new grant SHALL occur no earlier than the following cycle (IDLE cycle).
REQ-024 Latency: grant at cycle N SHALL give rsp_valid at cycle N+2; back-to-back throughput SHALL be one transaction per 3 cycles with rsp_ready held high.
REQ-025 Shift amount SHALL be taken modulo W (LOG2W bits); sel = 0 SHALL return operand unchanged.
REQ-026 Arithmetic left shift SHALL behave as logical left shift; rotate SHALL ignore shift_t.
REQ-027 Requests deasserted before grant SHALL be dropped without side effects; no request queuing.

Reset
REQ-028 On rst: state IDLE, req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, operand registers = 0, last-grant pointer = 1.
REQ-029 rst asserted in EXEC or RESP SHALL abort the transaction; no response SHALL be issued for it.
REQ-030 rst SHALL override all inputs in the same cycle.

Structure
REQ-031 Shared package SHALL hold FSM state encoding (IDLE, EXEC, RESP) and dir/op/shift_t encoding constants.
REQ-032 Single sub-module: barrel_shifter (ports dir, op, shift_t, sel, in, out), instantiated once with W and LOG2W passed through.
REQ-033 All outputs SHALL be registered; no combinational path from inputs to outputs.

Verification
REQ-034 Req0 only, dir=1, op=0, shift_t=1, sel=2, in=8'b1000_0000, rsp_ready=1 -> req_ready=2'b01 at N, rsp_valid at N+2, rsp_data=8'b1110_0000, rsp_id=0.
REQ-035 Both valid continuously for 4 transactions, rsp_ready=1 -> grants in order 0,1,0,1, each response 3 cycles apart.
REQ-036 Req1 dir=0, op=1, sel=3, in=8'hA5, rsp_ready=0 for 5 cycles then 1 -> rsp_data=8'h2D held stable, rsp_id=1, one response only.
REQ-037 Req0 dir=1, op=0, shift_t=0, sel=7, in=8'hFF -> rsp_data=8'h01; sel=0, in=8'h5A -> rsp_data=8'h5A.
REQ-038 rst pulsed in EXEC after grant of req1 -> no rsp_valid; next tie grants requester 0; all outputs 0 during reset.
REQ-039 Scoreboard: every accepted request produces exactly one response with matching id and expected shift result.

Source files
------------

// File: rtl/barrel_shift_arbiter_pkg.sv
// Shared definitions for the two-requester barrel shift arbiter.
// Holds the FSM state encoding and the dir/op/fill-type encodings.
package barrel_shift_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic DIR_LEFT   = 1'b0;
    localparam logic DIR_RIGHT  = 1'b1;
    localparam logic OP_SHIFT   = 1'b0;
    localparam logic OP_ROTATE  = 1'b1;
    localparam logic FILL_LOGIC = 1'b0;
    localparam logic FILL_ARITH = 1'b1;

endpackage

// File: rtl/barrel_shift_arbiter_shifter.sv
// Combinational barrel shifter: shift or rotate, left or right.
// Ports: dir, op, shift_t (fill type), sel (amount mod W), in, out.
module barrel_shifter
    import barrel_shift_arbiter_pkg::*;
#(
    parameter int W     = 8,
    parameter int LOG2W = 3
) (
    input  logic             dir,
    input  logic             op,
    input  logic             shift_t,
    input  logic [LOG2W-1:0] sel,
    input  logic [W-1:0]     in,
    output logic [W-1:0]     out
);

    logic [2*W-1:0]   dbl;
    logic [LOG2W-1:0] rot_amt;
    logic [W-1:0]     rot;

    // A left rotate by n equals a right rotate by (W - n) mod W,
    // so one right-shifted doubled operand serves both directions.
    assign dbl     = {in, in};
    assign rot_amt = (dir == DIR_RIGHT) ? sel : LOG2W'(0) - sel;
    assign rot     = W'(dbl >> rot_amt);

    always_comb begin
        out = in;
        if (op == OP_ROTATE) begin
            out = rot;
        end else if (dir == DIR_LEFT) begin
            out = in << sel;
        end else if (shift_t == FILL_ARITH) begin
            out = $signed(in) >>> sel;
        end else begin
            out = in >> sel;
        end
    end

endmodule

// File: rtl/barrel_shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter between two requesters.
// Ports: clk, rst, req_* (per-requester request bundle), rsp_* (response).
module barrel_shift_arbiter
    import barrel_shift_arbiter_pkg::*;
#(
    parameter int W     = 8,
    parameter int LOG2W = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [1:0]         req_dir,
    input  logic [1:0]         req_op,
    input  logic [1:0]         req_shift_t,
    input  logic [2*LOG2W-1:0] req_sel,
    input  logic [2*W-1:0]     req_in,
    output logic               rsp_valid,
    output logic               rsp_id,
    output logic [W-1:0]       rsp_data,
    input  logic               rsp_ready
);

    state_t           state, state_n;
    logic             gnt, gnt_id, last;
    logic             op_dir, op_op, op_st, op_id;
    logic [LOG2W-1:0] op_sel;
    logic [W-1:0]     op_in, sh_out;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // On a tie the requester that was not granted last wins.
    always_comb begin
        state_n   = state;
        gnt       = 1'b0;
        gnt_id    = 1'b0;
        req_ready = 2'b00;
        case (state)
            IDLE: begin
                if (|req_valid) begin
                    gnt     = 1'b1;
                    gnt_id  = (&req_valid) ? ~last : req_valid[1];
                    state_n = EXEC;
                end
            end
            EXEC:    state_n = RESP;
            RESP:    if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (gnt && !rst) req_ready = gnt_id ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last      <= 1'b1;
            op_dir    <= 1'b0;
            op_op     <= 1'b0;
            op_st     <= 1'b0;
            op_id     <= 1'b0;
            op_sel    <= '0;
            op_in     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt) begin
                        last   <= gnt_id;
                        op_id  <= gnt_id;
                        op_dir <= req_dir[gnt_id];
                        op_op  <= req_op[gnt_id];
                        op_st  <= req_shift_t[gnt_id];
                        op_sel <= gnt_id ? req_sel[2*LOG2W-1:LOG2W]
                                         : req_sel[LOG2W-1:0];
                        op_in  <= gnt_id ? req_in[2*W-1:W]
                                         : req_in[W-1:0];
                    end
                end
                EXEC: begin
                    rsp_data  <= sh_out;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    barrel_shifter #(
        .W     (W),
        .LOG2W (LOG2W)
    ) u_shifter (
        .dir     (op_dir),
        .op      (op_op),
        .shift_t (op_st),
        .sel     (op_sel),
        .in      (op_in),
        .out     (sh_out)
    );

endmodule
